hyperbus_burst_splitter: RTL and testbench

Command-path stage directly upstream of the HyperBus macro. It takes one AXI INCR burst command per handshake and emits a sequence of sub-burst commands. No sub-burst crosses a 2^PAGE_BITS-byte page boundary, and none exceeds MAX_BEATS beats. This lets the PHY-side controller keep CS low only within a single HyperRAM row/page and bounds CS-low time. Runs in the system clock domain, between the AXI AR/AW front end and the macro command port.

---
 rtl/hyperbus_pkg.sv | 27 ++
 rtl/hyperbus_chunk_calc.sv | 44 ++++
 rtl/hyperbus_burst_splitter.sv | 115 +++++++++++
 tb/tb_hyperbus_burst_splitter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hyperbus_pkg.sv
// Shared types and default geometry for the HyperBus burst splitter.
// The packed command struct mirrors the splitter's output fields.
package hyperbus_pkg;

  localparam int HB_AXI_AW      = 32;
  localparam int HB_AXI_IW      = 10;
  localparam int HB_BURST_WIDTH = 9;
  localparam int HB_PAGE_BITS   = 10;
  localparam int HB_MAX_BEATS   = 64;
  localparam int PAGE_BYTES     = 1 << HB_PAGE_BITS;

  typedef struct packed {
    logic [HB_AXI_AW-1:0]      addr;
    logic [HB_BURST_WIDTH-1:0] beats_m1;
    logic [2:0]                size;
    logic                      write;
    logic [HB_AXI_IW-1:0]      id;
    logic                      first;
    logic                      last;
  } hyperbus_split_cmd_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } split_state_e;

endpackage

// File: rtl/hyperbus_chunk_calc.sv
// Combinational sizing of one sub-burst: limited by the remaining beats,
// the distance to the next page boundary and MAX_BEATS.
module hyperbus_chunk_calc #(
  parameter int AXI_AW      = 32,
  parameter int BURST_WIDTH = 9,
  parameter int PAGE_BITS   = 10,
  parameter int MAX_BEATS   = 64
) (
  input  logic [AXI_AW-1:0]      i_cur_addr,
  input  logic [BURST_WIDTH-1:0] i_remaining,
  input  logic [2:0]             i_size,
  output logic [BURST_WIDTH-1:0] o_beats,
  output logic [AXI_AW-1:0]      o_next_addr,
  output logic                   o_is_last
);

  // Wide enough for a full page count (size 0) and for 256 beats.
  localparam int W0     = (PAGE_BITS + 1 > BURST_WIDTH) ? PAGE_BITS + 1 : BURST_WIDTH;
  localparam int CALC_W = (W0 > 9) ? W0 : 9;
  localparam logic [CALC_W-1:0] PAGE_SPAN = CALC_W'(1) << PAGE_BITS;
  localparam logic [CALC_W-1:0] MAX_B     = CALC_W'(MAX_BEATS);

  logic [AXI_AW-1:0]    w_mask;
  logic [AXI_AW-1:0]    w_aligned;
  logic [PAGE_BITS-1:0] w_off;
  logic [CALC_W-1:0]    w_to_page;
  logic [CALC_W-1:0]    w_rem;
  logic [CALC_W-1:0]    w_min_a;
  logic [CALC_W-1:0]    w_beats;

  assign w_mask    = ~((AXI_AW'(1) << i_size) - AXI_AW'(1));
  assign w_aligned = i_cur_addr & w_mask;
  assign w_off     = w_aligned[PAGE_BITS-1:0];
  assign w_to_page = (PAGE_SPAN - CALC_W'(w_off)) >> i_size;
  assign w_rem     = CALC_W'(i_remaining);
  assign w_min_a   = (w_rem < w_to_page) ? w_rem : w_to_page;
  assign w_beats   = (w_min_a < MAX_B) ? w_min_a : MAX_B;

  assign o_beats     = BURST_WIDTH'(w_beats);
  // Later chunks restart from the aligned address, dropping any unaligned offset.
  assign o_next_addr = w_aligned + (AXI_AW'(o_beats) << i_size);
  assign o_is_last   = (w_beats == w_rem);

endmodule

// File: rtl/hyperbus_burst_splitter.sv
// Splits one AXI INCR command into sub-bursts that never cross a page and
// never exceed MAX_BEATS beats, for the HyperBus macro command port.
module hyperbus_burst_splitter
  import hyperbus_pkg::*;
#(
  parameter int AXI_AW      = HB_AXI_AW,
  parameter int AXI_IW      = HB_AXI_IW,
  parameter int BURST_WIDTH = HB_BURST_WIDTH,
  parameter int PAGE_BITS   = HB_PAGE_BITS,
  parameter int MAX_BEATS   = HB_MAX_BEATS
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [AXI_AW-1:0]      in_addr_i,
  input  logic [7:0]             in_len_i,
  input  logic [2:0]             in_size_i,
  input  logic                   in_write_i,
  input  logic [AXI_IW-1:0]      in_id_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [AXI_AW-1:0]      out_addr_o,
  output logic [BURST_WIDTH-1:0] out_beats_m1_o,
  output logic [2:0]             out_size_o,
  output logic                   out_write_o,
  output logic [AXI_IW-1:0]      out_id_o,
  output logic                   out_first_o,
  output logic                   out_last_o,
  output split_state_e           dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid never drops and its fields never change until then.

  split_state_e           r_state;
  logic [AXI_AW-1:0]      r_cur_addr;
  logic [BURST_WIDTH-1:0] r_remaining;
  logic [2:0]             r_size;
  logic                   r_write;
  logic [AXI_IW-1:0]      r_id;
  logic                   r_first;

  logic [BURST_WIDTH-1:0] w_beats;
  logic [AXI_AW-1:0]      w_next_addr;
  logic                   w_is_last;
  logic                   w_busy;

  hyperbus_chunk_calc #(
    .AXI_AW      (AXI_AW),
    .BURST_WIDTH (BURST_WIDTH),
    .PAGE_BITS   (PAGE_BITS),
    .MAX_BEATS   (MAX_BEATS)
  ) u_chunk_calc (
    .i_cur_addr  (r_cur_addr),
    .i_remaining (r_remaining),
    .i_size      (r_size),
    .o_beats     (w_beats),
    .o_next_addr (w_next_addr),
    .o_is_last   (w_is_last)
  );

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_size      <= '0;
      r_write     <= 1'b0;
      r_id        <= '0;
      r_first     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid_i) begin
            r_state     <= BUSY;
            r_cur_addr  <= in_addr_i;
            r_remaining <= BURST_WIDTH'(in_len_i) + BURST_WIDTH'(1);
            r_size      <= in_size_i;
            r_write     <= in_write_i;
            r_id        <= in_id_i;
            r_first     <= 1'b1;
          end
        end
        BUSY: begin
          if (out_ready_i) begin
            r_first <= 1'b0;
            if (w_is_last) begin
              r_state <= IDLE;
            end else begin
              r_cur_addr  <= w_next_addr;
              r_remaining <= r_remaining - w_beats;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_busy = (r_state == BUSY);

  assign in_ready_o     = ~w_busy;
  assign out_valid_o    = w_busy;
  assign out_addr_o     = r_cur_addr;
  // Gated in IDLE so an empty remaining count never shows as all-ones.
  assign out_beats_m1_o = w_busy ? (w_beats - BURST_WIDTH'(1)) : '0;
  assign out_size_o     = r_size;
  assign out_write_o    = r_write;
  assign out_id_o       = r_id;
  assign out_first_o    = r_first;
  assign out_last_o     = w_busy & w_is_last;
  assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_hyperbus_burst_splitter.sv
// Directed bench for hyperbus_burst_splitter: the driver pushes hand-computed
// sub-bursts into a queue and a negedge monitor checks every output handshake.
module tb_hyperbus_burst_splitter;
  import hyperbus_pkg::*;

  localparam int SW = $bits(hyperbus_split_cmd_t);

  logic                      clk;
  logic                      rst;
  logic                      in_valid;
  logic                      in_ready;
  logic [HB_AXI_AW-1:0]      in_addr;
  logic [7:0]                in_len;
  logic [2:0]                in_size;
  logic                      in_write;
  logic [HB_AXI_IW-1:0]      in_id;
  logic                      out_valid;
  logic                      out_ready;
  logic [HB_AXI_AW-1:0]      out_addr;
  logic [HB_BURST_WIDTH-1:0] out_beats_m1;
  logic [2:0]                out_size;
  logic                      out_write;
  logic [HB_AXI_IW-1:0]      out_id;
  logic                      out_first;
  logic                      out_last;
  split_state_e              dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [SW-1:0] exp_q[$];
  hyperbus_split_cmd_t mon_got;
  hyperbus_split_cmd_t mon_exp;

  hyperbus_burst_splitter #(
    .AXI_AW(HB_AXI_AW), .AXI_IW(HB_AXI_IW), .BURST_WIDTH(HB_BURST_WIDTH),
    .PAGE_BITS(10), .MAX_BEATS(64)
  ) dut (
    .clk_sys_i      (clk),
    .rst_i          (rst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_addr_i      (in_addr),
    .in_len_i       (in_len),
    .in_size_i      (in_size),
    .in_write_i     (in_write),
    .in_id_i        (in_id),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_addr_o     (out_addr),
    .out_beats_m1_o (out_beats_m1),
    .out_size_o     (out_size),
    .out_write_o    (out_write),
    .out_id_o       (out_id),
    .out_first_o    (out_first),
    .out_last_o     (out_last),
    .dbg_state_o    (dbg_state)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      mon_got = '{addr: out_addr, beats_m1: out_beats_m1, size: out_size,
                  write: out_write, id: out_id, first: out_first, last: out_last};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_chunk: got addr=%h m1=%0d first=%0b last=%0b, required none",
                 out_addr, out_beats_m1, out_first, out_last);
      end else begin
        mon_exp = hyperbus_split_cmd_t'(exp_q.pop_front());
        if (mon_got !== mon_exp) begin
          n_errors++;
          $display("FAIL chunk: got addr=%h m1=%0d sz=%0d w=%0b id=%h f=%0b l=%0b, required addr=%h m1=%0d sz=%0d w=%0b id=%h f=%0b l=%0b",
                   mon_got.addr, mon_got.beats_m1, mon_got.size, mon_got.write, mon_got.id,
                   mon_got.first, mon_got.last, mon_exp.addr, mon_exp.beats_m1, mon_exp.size,
                   mon_exp.write, mon_exp.id, mon_exp.first, mon_exp.last);
        end
      end
    end
  end

  // Driver tasks
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_checks++;
    if (got !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] addr, input int m1, input logic [2:0] size,
                          input logic wr, input logic [9:0] id, input logic first,
                          input logic last);
    hyperbus_split_cmd_t c;
    c = '{addr: addr, beats_m1: HB_BURST_WIDTH'(m1), size: size, write: wr, id: id,
          first: first, last: last};
    exp_q.push_back(SW'(c));
  endtask

  task automatic send_cmd(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic wr, input logic [9:0] id);
    int budget;
    budget = 0;
    @(negedge clk);
    while (!in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL in_ready_timeout: got 0, required 1");
    end
    in_valid = 1'b1;
    in_addr  = addr;
    in_len   = len;
    in_size  = size;
    in_write = wr;
    in_id    = id;
    @(negedge clk);
    in_valid = 1'b0;
    in_addr  = '0;
    in_len   = '0;
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || !in_ready) && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    n_checks++;
    if (exp_q.size() != 0 || !in_ready) begin
      n_errors++;
      $display("FAIL %s_drain: got %0d pending, required 0", name, exp_q.size());
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_len    = '0;
    in_size   = '0;
    in_write  = 1'b0;
    in_id     = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_addr", 64'(out_addr), 64'd0);
    check("rst_beats_m1", 64'(out_beats_m1), 64'd0);
    check("rst_first_last", 64'({out_first, out_last}), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));

    // Single chunk
    push_exp(32'h100, 15, 3'd2, 1'b0, 10'h011, 1'b1, 1'b1);
    send_cmd(32'h100, 8'd15, 3'd2, 1'b0, 10'h011);
    wait_drain("single");

    // Page crossing
    push_exp(32'h3F0, 3, 3'd2, 1'b1, 10'h222, 1'b1, 1'b0);
    push_exp(32'h400, 3, 3'd2, 1'b1, 10'h222, 1'b0, 1'b1);
    send_cmd(32'h3F0, 8'd7, 3'd2, 1'b1, 10'h222);
    wait_drain("page_cross");

    // MAX_BEATS split
    for (int i = 0; i < 4; i++)
      push_exp(32'(i * 64), 63, 3'd0, 1'b0, 10'h3FF, i == 0, i == 3);
    send_cmd(32'h0, 8'd255, 3'd0, 1'b0, 10'h3FF);
    wait_drain("max_beats");

    // Unaligned start
    push_exp(32'h3FE, 0, 3'd2, 1'b1, 10'h005, 1'b1, 1'b0);
    push_exp(32'h400, 0, 3'd2, 1'b1, 10'h005, 1'b0, 1'b1);
    send_cmd(32'h3FE, 8'd1, 3'd2, 1'b1, 10'h005);
    wait_drain("unaligned");

    // Largest size: one beat reaches the page end
    push_exp(32'h380, 0, 3'd7, 1'b0, 10'h0A0, 1'b1, 1'b0);
    push_exp(32'h400, 0, 3'd7, 1'b0, 10'h0A0, 1'b0, 1'b1);
    send_cmd(32'h380, 8'd1, 3'd7, 1'b0, 10'h0A0);
    wait_drain("size7");

    // Backpressure on the second of three chunks
    for (int i = 0; i < 3; i++)
      push_exp(32'h1000 + 32'(i * 64), 63, 3'd0, 1'b1, 10'h155, i == 0, i == 2);
    send_cmd(32'h1000, 8'd191, 3'd0, 1'b1, 10'h155);
    @(posedge clk);
    #2 out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_addr", 64'(out_addr), 64'h1040);
      check("bp_beats_m1", 64'(out_beats_m1), 64'd63);
      check("bp_first_last", 64'({out_first, out_last}), 64'd0);
    end
    @(posedge clk);
    #2 out_ready = 1'b1;
    wait_drain("backpressure");

    // Reset during the second of three chunks
    push_exp(32'h2000, 63, 3'd0, 1'b0, 10'h0F0, 1'b1, 1'b0);
    send_cmd(32'h2000, 8'd191, 3'd0, 1'b0, 10'h0F0);
    @(posedge clk);
    #2 out_ready = 1'b0;
    @(negedge clk);
    check("mid_addr", 64'(out_addr), 64'h2040);
    check("mid_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 64'(out_valid), 64'd0);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_first_last", 64'({out_first, out_last}), 64'd0);
    check("post_rst_pending", 64'(exp_q.size()), 64'd0);
    #1 out_ready = 1'b1;

    push_exp(32'h800, 3, 3'd3, 1'b1, 10'h077, 1'b1, 1'b1);
    send_cmd(32'h800, 8'd3, 3'd3, 1'b1, 10'h077);
    wait_drain("after_reset");

    repeat (3) @(negedge clk);
    check("end_idle_valid", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
